// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Sequential instruction fetch front end. A fetch PC walks memory one word
//   per cycle. Each issued address returns data one cycle later; that word is
//   captured into a small {instr, pc} buffer that feeds the decode stage.
//   A redirect flushes the buffer, drops the word in flight and restarts
//   fetching at the (word-aligned) target.
//
// Ports:
//   clk_i          in   1   clock, all state updates on the rising edge
//   rst_i          in   1   synchronous active-high reset
//   redirect_i     in   1   branch/jump redirect request
//   redirect_pc_i  in  32   byte address of the redirect target
//   mem_addr_o     out 32   word address presented to memory
//   mem_wen_o      out  1   memory write enable, always 0
//   mem_data_i     in  32   read data, valid one cycle after mem_addr_o
//   instr_o        out 32   instruction at the buffer head
//   instr_pc_o     out 32   byte PC of instr_o
//   instr_valid_o  out  1   buffer head holds a valid instruction
//   instr_ready_i  in   1   decode accepts the head this cycle
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    // Storage is sized for the largest legal depth so the 3-bit pointers
    // index it exactly; slots at or above FIFO_DEPTH are never addressed.
    localparam int         MAX_DEPTH = 8;
    localparam logic [3:0] DEPTH_C   = 4'(FIFO_DEPTH);
    localparam logic [2:0] LAST_PTR  = 3'(FIFO_DEPTH - 1);

    logic [31:0] fetchPc_q, fetchPc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflightPc_q, inflightPc_d;
    logic [2:0]  head_q, head_d;
    logic [2:0]  tail_q, tail_d;
    logic [3:0]  count_q, count_d;

    logic [31:0] fifoInstr_q [MAX_DEPTH];
    logic [31:0] fifoPc_q    [MAX_DEPTH];

    logic       pop;
    logic       push;
    logic       issue;
    logic [3:0] occupancy;

    function automatic logic [2:0] nextPtr(input logic [2:0] ptr);
        return (ptr == LAST_PTR) ? 3'd0 : ptr + 3'd1;
    endfunction

    // Per-cycle decisions. Redirect suppresses pop, push and issue at once.
    // Occupancy counts the word in flight as already owning a slot, so an
    // issue is only allowed when its returning word is guaranteed room.
    always_comb begin
        pop       = (count_q != 4'd0) && instr_ready_i && !redirect_i;
        push      = inflight_q && !redirect_i;
        occupancy = count_q + {3'b000, inflight_q} - {3'b000, pop};
        issue     = !redirect_i && (occupancy < DEPTH_C);
    end

    // Next-state for fetch PC, in-flight tracker and buffer bookkeeping.
    // Masking the redirect target clears the byte offset so fetch always
    // resumes on the word containing it.
    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflight_d   = inflight_q;
        inflightPc_d = inflightPc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;

        if (redirect_i) begin
            fetchPc_d  = redirect_pc_i & 32'hFFFF_FFFC;
            inflight_d = 1'b0;
            head_d     = 3'd0;
            tail_d     = 3'd0;
            count_d    = 4'd0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                inflightPc_d = fetchPc_q;
                fetchPc_d    = fetchPc_q + 32'd4;
            end
            if (pop) begin
                head_d = nextPtr(head_q);
            end
            if (push) begin
                tail_d = nextPtr(tail_q);
            end
            count_d = count_q + {3'b000, push} - {3'b000, pop};
        end
    end

    // Control state register with synchronous reset, which overrides any
    // redirect presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetchPc_q    <= RESET_PC & 32'hFFFF_FFFC;
            inflight_q   <= 1'b0;
            inflightPc_q <= 32'd0;
            head_q       <= 3'd0;
            tail_q       <= 3'd0;
            count_q      <= 4'd0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // Buffer payload has no reset; the returning memory word is written
    // together with the PC it was fetched from.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            fifoInstr_q[tail_q] <= mem_data_i;
            fifoPc_q[tail_q]    <= inflightPc_q;
        end
    end

    // Head outputs are forced to zero while the buffer is empty so stale
    // payload never shows, including right after reset.
    always_comb begin
        instr_valid_o = (count_q != 4'd0);
        instr_o       = instr_valid_o ? fifoInstr_q[head_q] : 32'd0;
        instr_pc_o    = instr_valid_o ? fifoPc_q[head_q]    : 32'd0;
        mem_addr_o    = {2'b00, fetchPc_q[31:2]};
        mem_wen_o     = 1'b0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Purpose:
//   Self-checking bench for fetch_unit. A word-addressed memory model answers
//   fetches one cycle late. A transaction-level model (queue of expected
//   {instr, pc} entries plus one pending fetch) predicts every cycle's outputs,
//   and directed scenarios pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_data_i = 32'd0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_addr_o    (mem_addr_o),
        .mem_wen_o     (mem_wen_o),
        .mem_data_i    (mem_data_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    // Memory contents: the preloaded program in words 0..5, and elsewhere the
    // inverted word address so every location carries a distinct value.
    function automatic logic [31:0] memWord(input logic [31:0] wordAddr);
        case (wordAddr)
            32'd0:   return 32'h002081B3;
            32'd1:   return 32'd7;
            32'd2:   return 32'd9;
            32'd3:   return 32'd11;
            32'd4:   return 32'd13;
            32'd5:   return 32'd15;
            default: return ~wordAddr;
        endcase
    endfunction

    // Synchronous-read memory: the word for the address seen at this edge
    // appears on mem_data_i for the following cycle.
    always @(posedge clk) begin
        mem_data_i <= memWord(mem_addr_o);
    end

    // Transaction-level reference: a queue of buffered words, at most one
    // outstanding fetch, and the next byte PC to fetch.
    entry_t      mQueue[$];
    logic [31:0] mPc = 32'd0;
    bit          mPend = 1'b0;
    logic [31:0] mPendPc = 32'd0;
    bit          modelLive = 1'b0;
    bit          mPop;
    int          mOcc;

    always @(posedge clk) begin
        if (rst_i) begin
            mQueue.delete();
            mPend     = 1'b0;
            mPc       = RESET_PC & 32'hFFFF_FFFC;
            modelLive = 1'b1;
        end else if (redirect_i) begin
            mQueue.delete();
            mPend = 1'b0;
            mPc   = redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            mPop = (mQueue.size() != 0) && instr_ready_i;
            mOcc = mQueue.size() + int'(mPend) - int'(mPop);
            if (mPop) void'(mQueue.pop_front());
            if (mPend) mQueue.push_back('{memWord(mPendPc >> 2), mPendPc});
            if (mOcc < DEPTH) begin
                mPend   = 1'b1;
                mPendPc = mPc;
                mPc     = mPc + 32'd4;
            end else begin
                mPend = 1'b0;
            end
        end
    end

    // Every cycle, mid-period, compare all outputs against the reference.
    logic [31:0] eInstr, ePc, eAddr;
    logic        eValid;

    always @(negedge clk) begin
        if (modelLive) begin
            eValid = (mQueue.size() != 0);
            eInstr = eValid ? mQueue[0].instr : 32'd0;
            ePc    = eValid ? mQueue[0].pc    : 32'd0;
            eAddr  = {2'b00, mPc[31:2]};
            checks++;
            if (instr_valid_o !== eValid || instr_o !== eInstr || instr_pc_o !== ePc) begin
                failures++;
                $display("[TB] FAIL model_head t=%0t: got v=%0b i=%h pc=%h, want v=%0b i=%h pc=%h",
                         $time, instr_valid_o, instr_o, instr_pc_o, eValid, eInstr, ePc);
            end
            checks++;
            if (mem_addr_o !== eAddr || mem_wen_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL model_mem t=%0t: got addr=%h wen=%0b, want addr=%h wen=0",
                         $time, mem_addr_o, mem_wen_o, eAddr);
            end
        end
    end

    // Drive one cycle's inputs just after the rising edge that starts it.
    task automatic applyStimulus(input logic rst, input logic redir,
                                 input logic [31:0] rpc, input logic ready);
        @(posedge clk);
        #1;
        rst_i         = rst;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        instr_ready_i = ready;
    endtask

    // Hand-computed head check in the middle of the current cycle.
    task automatic checkOutput(input string name, input logic expValid,
                               input logic [31:0] expInstr, input logic [31:0] expPc);
        @(negedge clk);
        checks++;
        if (instr_valid_o !== expValid || instr_o !== expInstr || instr_pc_o !== expPc) begin
            failures++;
            $display("[TB] FAIL %s: got v=%0b i=%h pc=%h, want v=%0b i=%h pc=%h",
                     name, instr_valid_o, instr_o, instr_pc_o, expValid, expInstr, expPc);
        end
    endtask

    // Hand-computed memory address check; call right after checkOutput.
    task automatic checkAddr(input string name, input logic [31:0] expAddr);
        checks++;
        if (mem_addr_o !== expAddr) begin
            failures++;
            $display("[TB] FAIL %s: got addr=%h, want addr=%h", name, mem_addr_o, expAddr);
        end
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        int r;
        logic [31:0] rpc;

        // Start-up, in-order stream, then a redirect to 0x10 in cycle 4.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("reset_empty", 0, 32'd0, 32'd0);
        checkAddr("reset_addr", 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c0_empty", 0, 32'd0, 32'd0);
        checkAddr("c0_addr", 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c1_empty", 0, 32'd0, 32'd0);
        checkAddr("c1_addr", 32'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c2_first", 1, 32'h002081B3, 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c3_second", 1, 32'd7, 32'h4);
        applyStimulus(0, 1, 32'h10, 1);
        checkOutput("c4_redir_head", 1, 32'd9, 32'h8);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c5_flushed", 0, 32'd0, 32'd0);
        checkAddr("c5_target_addr", 32'd4);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c6_flushed", 0, 32'd0, 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c7_target", 1, 32'd13, 32'h10);
        applyStimulus(0, 0, 0, 1);
        checkOutput("c8_after_target", 1, 32'd15, 32'h14);

        // Backpressure in cycles 3-6, then reset while the buffer is full.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("bp_c2", 1, 32'h002081B3, 32'h0);
        for (int c = 3; c <= 6; c++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("bp_hold", 1, 32'd7, 32'h4);
        end
        applyStimulus(0, 0, 0, 1);
        checkOutput("bp_c7", 1, 32'd7, 32'h4);
        applyStimulus(0, 0, 0, 1);
        checkOutput("bp_c8", 1, 32'd9, 32'h8);
        applyStimulus(0, 0, 0, 1);
        checkOutput("bp_c9", 1, 32'd11, 32'hC);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rst_full_cleared", 0, 32'd0, 32'd0);
        checkAddr("rst_full_addr", 32'd0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rst_full_refetch", 1, 32'h002081B3, 32'h0);

        // Misaligned redirect target lands on the containing word.
        applyStimulus(0, 1, 32'h0000_0007, 1);
        applyStimulus(0, 0, 0, 1);
        checkAddr("misalign_addr", 32'd1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("misalign_out", 1, 32'd7, 32'h4);

        // Back-to-back redirects: only the second target appears.
        applyStimulus(0, 1, 32'h40, 1);
        applyStimulus(0, 1, 32'h10, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("b2b_gap1", 0, 32'd0, 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("b2b_gap2", 0, 32'd0, 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("b2b_last_wins", 1, 32'd13, 32'h10);

        // Fetch PC wraps from the top word to zero.
        applyStimulus(0, 1, 32'hFFFF_FFFC, 1);
        applyStimulus(0, 0, 0, 1);
        checkAddr("wrap_addr", 32'h3FFF_FFFF);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrap_top", 1, 32'hC000_0000, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrap_zero", 1, 32'h002081B3, 32'h0);

        // Reset wins over a simultaneous redirect.
        applyStimulus(1, 1, 32'h40, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rst_over_redir", 1, 32'h002081B3, 32'h0);

        // Randomized soak against the reference model.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 2))
                0:       rpc = $urandom_range(0, 31);
                1:       rpc = 32'hFFFF_FFE0 + $urandom_range(0, 31);
                default: rpc = $urandom;
            endcase
            applyStimulus((r == 0), ($urandom_range(0, 99) < 5), rpc,
                          ($urandom_range(0, 99) < 70));
        end
        applyStimulus(0, 0, 0, 1);
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction-buffer entries; legal range 2..8.
REQ-003 clk_i  input  1  single clock; all state updates on posedge clk_i.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 redirect_i  input  1  branch/jump redirect request.
REQ-006 redirect_pc_i  input  32  byte address of the redirect target.
REQ-007 mem_addr_o  output  32  word address to the memory model, equal to {2'b00, fetch_pc[31:2]}.
REQ-008 mem_wen_o  output  1  memory write enable; tied to 0 at all times.
REQ-009 mem_data_i  input  32  memory read data, valid one cycle after mem_addr_o is presented.
REQ-010 instr_o  output  32  instruction word at the FIFO head.
REQ-011 instr_pc_o  output  32  byte PC of instr_o.
REQ-012 instr_valid_o  output  1  FIFO head holds a valid instruction.
REQ-013 instr_ready_i  input  1  downstream decode accepts the head this cycle.

Function
REQ-014 The block SHALL hold a fetch_pc register, a one-deep in-flight tracker (inflight bit plus inflight_pc) and a FIFO_DEPTH-entry FIFO of {instr, pc} pairs.
REQ-015 mem_addr_o SHALL be driven combinationally from fetch_pc in every cycle, whether or not an issue occurs.
REQ-016 Pop SHALL occur when instr_valid_o && instr_ready_i.
REQ-017 Issue SHALL occur when !redirect_i && (count + inflight - pop) < FIFO_DEPTH.
REQ-018 On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-019 Without issue: inflight <= 0 and fetch_pc holds.
REQ-020 When inflight == 1 and no redirect: {mem_data_i, inflight_pc} SHALL be pushed into the FIFO in that cycle.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-022 The FIFO SHALL never overflow; by REQ-017 a push always has a free slot.
REQ-023 instr_valid_o = (count != 0); instr_o and instr_pc_o come from the head entry and are registered state, not combinational from mem_data_i.
REQ-024 While instr_valid_o && !instr_ready_i, instr_o and instr_pc_o SHALL be held stable.
REQ-025 Latency: issue in cycle N -> instr_valid_o for that word in cycle N+2, if the FIFO was empty.
REQ-026 Throughput: with instr_ready_i held high, one instruction per cycle SHALL be sustained after startup.
REQ-027 Redirect has priority over issue, push and pop. In the redirect cycle:
  - FIFO cleared (count <= 0);
  - inflight <= 0, so the response arriving next cycle is discarded;
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00};
  - no pop, even if instr_ready_i is high.
REQ-028 After a redirect: first issue of the target in cycle R+1; target instruction valid in cycle R+3.
REQ-029 Back-to-back redirects: the last redirect wins; no instruction from an earlier target SHALL appear.
REQ-030 Output order SHALL equal issue order; PCs are strictly increasing by 4 between redirects.

Reset
REQ-031 While rst_i is sampled high:
  - fetch_pc <= RESET_PC[31:2] word-aligned, inflight <= 0, FIFO count <= 0;
  - instr_valid_o = 0 in the following cycle; mem_wen_o = 0.
REQ-032 The data-path entries instr_o and instr_pc_o need no reset but SHALL read 0 after reset when count == 0.
REQ-033 rst_i has priority over redirect_i.
REQ-034 Reset asserted mid-operation SHALL discard all buffered and in-flight words.
REQ-035 The first issue SHALL occur in the first cycle with rst_i low.

Verification
REQ-036 Memory preload: words 0..5 = 32'h002081B3, 7, 9, 11, 13, 15; RESET_PC = 0; ready high.
  -> release reset in cycle 0;
  -> valid from cycle 2;
  -> outputs {32'h002081B3 @pc 0x0}, {7 @0x4}, {9 @0x8}, ... one per cycle.
REQ-037 Backpressure: ready low in cycles 3-6 -> head held stable, count saturates at FIFO_DEPTH, no word lost or duplicated, order resumes when ready rises.
REQ-038 Redirect with redirect_pc_i = 32'h10 in cycle 4 -> no valid in cycles 5-6, then {13 @pc 0x10} in cycle 7; the in-flight word from before the redirect is never output.
REQ-039 Redirect with redirect_pc_i = 32'h0000_0007 -> fetch proceeds from 0x4, outputting {7 @0x4}.
REQ-040 Reset asserted for one cycle while the FIFO is full -> valid low next cycle, refetch from RESET_PC, first output 32'h002081B3 two cycles after reset release.
REQ-041 fetch_pc = 32'hFFFF_FFFC issued -> next issue at 0x0, output PCs 0xFFFF_FFFC then 0x0.
